// File: rtl/mfcc_frame_streamer.sv
// mfcc_frame_streamer: ping-pong frame buffer that re-emits each N_FEAT-word
// MFCC feature frame as one unbroken valid burst followed by at least GAP idle cycles.
// Ports:
//   clk              rising-edge clock
//   reset            asynchronous active-low reset
//   s_tvalid/s_tdata producer word, frame order (index 0 first)
//   s_tready         write side can accept (target bank not full)
//   tvalid_mfcc_feat registered output valid, N_FEAT consecutive cycles per frame
//   mfcc_feat        registered output word, 0 whenever not valid
//   mfcc_last        high with the final word of each burst
module mfcc_frame_streamer #(
    parameter int N_FEAT = 39,
    parameter int DATA_W = 32,
    parameter int GAP    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_tvalid,
    input  logic [DATA_W-1:0] s_tdata,
    output logic              s_tready,
    output logic              tvalid_mfcc_feat,
    output logic [DATA_W-1:0] mfcc_feat,
    output logic              mfcc_last
);
    localparam logic [5:0] LAST = 6'(N_FEAT - 1);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);

    typedef enum logic [1:0] {S_IDLE, S_BURST, S_GAP} state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_mem [2][N_FEAT];
    logic [1:0]        r_full;
    logic              r_wr_bank;
    logic              r_rd_bank;
    logic [5:0]        r_wr_idx;
    logic [5:0]        r_rd_idx;
    logic [GW-1:0]     r_gap_cnt;
    logic              w_acc;
    logic              w_wr_last;
    logic              w_rd_last;
    logic [1:0]        w_set;
    logic [1:0]        w_rel;

    assign s_tready  = !r_full[r_wr_bank];
    assign w_acc     = s_tvalid && s_tready;
    assign w_wr_last = w_acc && (r_wr_idx == LAST);
    assign w_rd_last = (r_state == S_BURST) && (r_rd_idx == LAST);
    // Writer only completes an empty bank and reader only releases a full one,
    // so set and release always target different banks in the same cycle.
    assign w_set = w_wr_last ? (r_wr_bank ? 2'b10 : 2'b01) : 2'b00;
    assign w_rel = w_rd_last ? (r_rd_bank ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge clk) begin
        if (w_acc)
            r_mem[r_wr_bank][r_wr_idx] <= s_tdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state          <= S_IDLE;
            r_full           <= 2'b00;
            r_wr_bank        <= 1'b0;
            r_rd_bank        <= 1'b0;
            r_wr_idx         <= '0;
            r_rd_idx         <= '0;
            r_gap_cnt        <= '0;
            tvalid_mfcc_feat <= 1'b0;
            mfcc_feat        <= '0;
            mfcc_last        <= 1'b0;
        end else begin
            if (w_acc) begin
                r_wr_idx <= w_wr_last ? 6'd0 : r_wr_idx + 6'd1;
                if (w_wr_last)
                    r_wr_bank <= ~r_wr_bank;
            end
            r_full <= (r_full & ~w_rel) | w_set;
            case (r_state)
                S_IDLE: begin
                    if (r_full[r_rd_bank]) begin
                        mfcc_feat        <= r_mem[r_rd_bank][0];
                        tvalid_mfcc_feat <= 1'b1;
                        r_rd_idx         <= 6'd1;
                        r_state          <= S_BURST;
                    end
                end
                S_BURST: begin
                    mfcc_feat <= r_mem[r_rd_bank][r_rd_idx];
                    r_rd_idx  <= r_rd_idx + 6'd1;
                    if (w_rd_last) begin
                        mfcc_last <= 1'b1;
                        r_rd_bank <= ~r_rd_bank;
                        r_gap_cnt <= '0;
                        r_state   <= S_GAP;
                    end
                end
                default: begin
                    tvalid_mfcc_feat <= 1'b0;
                    mfcc_feat        <= '0;
                    mfcc_last        <= 1'b0;
                    if (r_gap_cnt == GAP_LAST)
                        r_state <= S_IDLE;
                    else
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mfcc_frame_streamer.sv
// tb_mfcc_frame_streamer: directed bench for mfcc_frame_streamer with GAP=1 and GAP=3 instances.
module tb_mfcc_frame_streamer;
    localparam int NF = 39;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        s_tvalid = 1'b0;
    logic [31:0] s_tdata = '0;
    logic        s_tready;
    logic        tv0;
    logic [31:0] d0;
    logic        l0;
    logic        s1_tvalid = 1'b0;
    logic [31:0] s1_tdata = '0;
    logic        s1_tready;
    logic        tv1;
    logic [31:0] d1;
    logic        l1;

    int n_tests = 0;
    int n_fail  = 0;
    int resync[2]  = '{0, 0};
    bit gap_chk[2] = '{0, 0};
    int bursts[2]  = '{0, 0};
    bit st = 0;

    always #5 clk = ~clk;

    mfcc_frame_streamer #(.N_FEAT(NF), .DATA_W(32), .GAP(1)) dut0 (
        .clk(clk), .reset(reset), .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tready(s_tready),
        .tvalid_mfcc_feat(tv0), .mfcc_feat(d0), .mfcc_last(l0));

    mfcc_frame_streamer #(.N_FEAT(NF), .DATA_W(32), .GAP(3)) dut1 (
        .clk(clk), .reset(reset), .s_tvalid(s1_tvalid), .s_tdata(s1_tdata), .s_tready(s1_tready),
        .tvalid_mfcc_feat(tv1), .mfcc_feat(d1), .mfcc_last(l1));

    function automatic logic [31:0] word(input int f, input int i);
        return 32'h3F800000 + 32'(f * 256 + i);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Per-instance output monitor: data order, last flag, burst length, idle zeros, gap length.
    task automatic mon(input int sel);
        int pos = 0;
        int mf = 0;
        int idle = 0;
        bit armed = 0;
        logic v;
        logic l;
        logic [31:0] d;
        forever begin
            @(negedge clk);
            v = (sel == 1) ? tv1 : tv0;
            l = (sel == 1) ? l1 : l0;
            d = (sel == 1) ? d1 : d0;
            if (!reset) begin
                pos = 0;
                idle = 0;
                armed = 0;
                mf = resync[sel];
            end else if (v) begin
                if (pos == 0 && armed && gap_chk[sel])
                    chk("gap_len", 32'(idle), (sel == 1) ? 32'd3 : 32'd1);
                chk("data", d, word(mf, pos));
                chk("last", 32'(l), 32'(pos == NF - 1));
                pos++;
                idle = 0;
            end else begin
                if (pos != 0) begin
                    chk("burst_len", 32'(pos), 32'(NF));
                    pos = 0;
                    mf++;
                    bursts[sel]++;
                    armed = gap_chk[sel];
                end
                idle++;
                chk("idle_zero", d | 32'(l), 32'd0);
            end
        end
    endtask

    task automatic send(input int sel, input logic [31:0] w);
        bit acc;
        int t = 0;
        if (sel == 0) begin
            s_tvalid = 1'b1;
            s_tdata  = w;
        end else begin
            s1_tvalid = 1'b1;
            s1_tdata  = w;
        end
        do begin
            acc = (sel == 1) ? s1_tready : s_tready;
            if (!acc) st = 1;
            @(posedge clk);
            #1;
            t++;
        end while (!acc && t < 500);
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
        s_tvalid  = 1'b0;
        s1_tvalid = 1'b0;
    endtask

    task automatic send_frame(input int sel, input int f, input int space);
        for (int i = 0; i < NF; i++) begin
            send(sel, word(f, i));
            repeat (space) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        int t;
        fork
            mon(0);
            mon(1);
        join_none
        repeat (3) begin
            @(negedge clk);
            chk("rst_tvalid", 32'(tv0), 32'd0);
            chk("rst_data", d0, 32'd0);
            chk("rst_last", 32'(l0), 32'd0);
        end
        reset = 1'b1;
        @(negedge clk);
        chk("rel_ready0", 32'(s_tready), 32'd1);
        chk("rel_ready1", 32'(s1_tready), 32'd1);
        chk("rel_tvalid", 32'(tv0), 32'd0);

        send_frame(0, 0, 0);
        chk("lat_e0", 32'(tv0), 32'd0);
        @(negedge clk);
        chk("lat_before", 32'(tv0), 32'd0);
        @(negedge clk);
        chk("lat_first", 32'(tv0), 32'd1);
        chk("lat_word0", d0, word(0, 0));
        repeat (50) @(negedge clk);
        chk("frames_single", 32'(bursts[0]), 32'd1);

        send_frame(0, 1, 2);
        repeat (50) @(negedge clk);
        chk("frames_sparse", 32'(bursts[0]), 32'd2);

        gap_chk[0] = 1;
        st = 0;
        for (int f = 2; f < 6; f++) send_frame(0, f, 0);
        chk("backpressure", 32'(st), 32'd1);
        repeat (100) @(negedge clk);
        chk("frames_cont", 32'(bursts[0]), 32'd6);
        gap_chk[0] = 0;

        send_frame(0, 6, 0);
        t = 0;
        while (!tv0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("rst_wait", 32'(tv0), 32'd1);
        repeat (19) @(negedge clk);
        chk("pre_rst_word", d0, word(6, 19));
        resync[0] = 7;
        #1 reset = 1'b0;
        #1;
        chk("async_tvalid", 32'(tv0), 32'd0);
        chk("async_data", d0, 32'd0);
        chk("async_last", 32'(l0), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(s_tready), 32'd1);
        repeat (20) @(negedge clk);
        chk("no_residual", 32'(tv0), 32'd0);
        send_frame(0, 7, 0);
        repeat (50) @(negedge clk);
        chk("frames_after_rst", 32'(bursts[0]), 32'd7);

        gap_chk[1] = 1;
        for (int f = 0; f < 3; f++) send_frame(1, f, 0);
        repeat (150) @(negedge clk);
        chk("frames_gap3", 32'(bursts[1]), 32'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
